mux_rr_arbiter: RTL and testbench

//  Shares one mux_8x1 datapath between 8 requesters via a round-robin arbiter with bounded bursts.

---
 rtl/mux_rr_arbiter_pkg.sv | 26 ++
 rtl/mux_rr_arbiter_mux.sv | 17 +
 rtl/mux_rr_arbiter.sv | 92 +++++++++
 tb/tb_mux_rr_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, requester index type and the rotating
// priority pick used by the round-robin arbiter.
package mux_rr_arbiter_pkg;

   localparam int NUM_REQ = 8;
   localparam int SRC_W   = 3;

   typedef logic [SRC_W-1:0]   req_idx_t;
   typedef logic [NUM_REQ-1:0] req_vec_t;

   // First set bit scanning start, start+1, ... with wrap.
   function automatic req_idx_t rr_pick(
      input req_vec_t req,
      input req_idx_t start
   );
      req_idx_t res;
      req_idx_t idx;
      res = start;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = start + req_idx_t'(i);
         if (req[idx]) res = idx;
      end
      return res;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// 8:1 word multiplexer shared by all requesters.
// Purely combinational; select comes from the arbiter grant.
module mux_8x1
   import mux_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [SRC_W-1:0]         sel_i,
   input  logic [NUM_REQ*WIDTH-1:0] data_i,
   output logic [WIDTH-1:0]         data_o
);

   always_comb begin
      data_o = data_i[32'(sel_i)*WIDTH +: WIDTH];
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with bounded bursts feeding one registered
// valid/ready output stage through a shared 8:1 data mux.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int BURST_MAX = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NUM_REQ-1:0]       REQ,
   input  logic [NUM_REQ*WIDTH-1:0] IN_BUS,
   output logic [NUM_REQ-1:0]       ACK,
   output logic [WIDTH-1:0]         OUT_DATA,
   output logic [SRC_W-1:0]         OUT_SRC,
   output logic                     OUT_VALID,
   input  logic                     OUT_READY
);

   localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

   req_idx_t         ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   req_idx_t         src_q, src_d;

   logic             load;
   logic             keep;
   req_idx_t         grant;
   logic [WIDTH-1:0] mux_out;

   mux_8x1 #(
      .WIDTH (WIDTH)
   ) u_data_mux (
      .sel_i  (grant),
      .data_i (IN_BUS),
      .data_o (mux_out)
   );

   // Owner keeps the grant while requesting and under its burst limit.
   always_comb begin
      load  = (|REQ) & (~valid_q | OUT_READY);
      keep  = REQ[ptr_q] & (cnt_q < CNT_LAST);
      grant = keep ? ptr_q : rr_pick(REQ, ptr_q + req_idx_t'(1));
      ACK   = '0;
      if (load && !RST) ACK = NUM_REQ'(1) << grant;
   end

   always_comb begin
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      data_d  = data_q;
      src_d   = src_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = mux_out;
         src_d   = grant;
         if (keep) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            ptr_d = grant;
            cnt_d = '0;
         end
      end else if (OUT_READY) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ptr_q   <= req_idx_t'(NUM_REQ - 1);
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

   assign OUT_DATA  = data_q;
   assign OUT_SRC   = src_q;
   assign OUT_VALID = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench: two arbiters (burst 1 and burst 4) share stimulus,
// each checked against its own behavioural round-robin model.
module tb_mux_rr_arbiter;

   localparam int W = 16;

   typedef struct packed {
      logic [2:0]   src;
      logic [W-1:0] data;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [7:0]   req;
   logic [8*W-1:0] in_bus;
   logic         ready;

   int checks   = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int B = (g == 0) ? 1 : 4;

      logic [7:0]   ack;
      logic [W-1:0] odata;
      logic [2:0]   osrc;
      logic         ovalid;
      exp_t         exp_q[$];

      mux_rr_arbiter #(
         .WIDTH     (W),
         .BURST_MAX (B)
      ) u_dut (
         .CLK       (clk),
         .RST       (rst),
         .REQ       (req),
         .IN_BUS    (in_bus),
         .ACK       (ack),
         .OUT_DATA  (odata),
         .OUT_SRC   (osrc),
         .OUT_VALID (ovalid),
         .OUT_READY (ready)
      );

      // Monitor: the front of the queue is the word being presented.
      initial begin
         exp_t e;
         forever begin
            @(negedge clk);
            if (!rst) begin
               check($sformatf("L%0d valid", g), 32'(ovalid),
                     32'(exp_q.size() != 0));
               if (ovalid && exp_q.size() != 0) begin
                  e = exp_q[0];
                  check($sformatf("L%0d src", g), 32'(osrc), 32'(e.src));
                  check($sformatf("L%0d data", g), 32'(odata), 32'(e.data));
                  if (ready) void'(exp_q.pop_front());
               end
            end
         end
      end

      // Reference model: owner, burst length, output-occupied flag.
      initial begin
         int  owner;
         int  burst;
         bit  mv;
         bit  load;
         bit  cont;
         int  gnt;
         exp_t e;
         owner = 7; burst = 0; mv = 0;
         forever begin
            @(negedge clk);
            #1;
            if (rst) begin
               check($sformatf("L%0d ack_in_reset", g), 32'(ack), 0);
               exp_q.delete();
               owner = 7; burst = 0; mv = 0;
            end else begin
               load = (req != 0) && (!mv || ready);
               cont = req[owner] && (burst + 1 < B);
               gnt  = owner;
               if (load && !cont) begin
                  for (int k = 8; k >= 1; k--)
                     if (req[(owner + k) % 8]) gnt = (owner + k) % 8;
               end
               check($sformatf("L%0d ack", g), 32'(ack),
                     load ? (32'd1 << gnt) : 32'd0);
               if (load) begin
                  e.src  = 3'(gnt);
                  e.data = in_bus[gnt*W +: W];
                  exp_q.push_back(e);
                  if (cont) burst++;
                  else begin owner = gnt; burst = 0; end
                  mv = 1;
               end else if (ready) begin
                  mv = 0;
               end
            end
         end
      end
   end

   task automatic drive(input logic [7:0] r, input logic rd, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         req   = r;
         ready = rd;
         for (int k = 0; k < 8; k++) in_bus[k*W +: W] = W'($urandom);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " L0 valid"}, 32'(lane[0].ovalid), 0);
      check({tag, " L1 valid"}, 32'(lane[1].ovalid), 0);
      check({tag, " L0 ack"},   32'(lane[0].ack), 0);
      check({tag, " L1 ack"},   32'(lane[1].ack), 0);
      check({tag, " L1 data"},  32'(lane[1].odata), 0);
      check({tag, " L1 src"},   32'(lane[1].osrc), 0);
      check({tag, " L0 ptr"},   32'(lane[0].u_dut.ptr_q), 7);
      check({tag, " L1 ptr"},   32'(lane[1].u_dut.ptr_q), 7);
      check({tag, " L1 cnt"},   32'(lane[1].u_dut.cnt_q), 0);
   endtask

   initial begin
      rst    = 1'b1;
      req    = '0;
      ready  = 1'b1;
      in_bus = '0;
      repeat (2) @(posedge clk);
      #3;
      check_reset_state("por");
      rst = 1'b0;

      drive(8'hFF, 1'b1, 20);
      drive(8'h24, 1'b1, 20);
      drive(8'h48, 1'b1, 2);
      drive(8'h40, 1'b1, 4);
      drive(8'h01, 1'b0, 5);
      drive(8'h01, 1'b1, 3);
      drive(8'h81, 1'b1, 12);
      drive(8'h10, 1'b1, 8);

      drive(8'hFF, 1'b1, 3);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_state("async");
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;

      for (int i = 0; i < 400; i++) begin
         logic [7:0] r;
         r = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 9) == 0) r = '0;
         drive(r, 1'($urandom_range(0, 3) != 0), 1);
      end

      drive(8'h00, 1'b1, 5);
      @(negedge clk);
      #2;
      check("L0 drained", 32'(lane[0].exp_q.size()), 0);
      check("L1 drained", 32'(lane[1].exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
